rmw_long_latency_tbl: RTL and testbench

- Behavioural/synthesizable model of the long-latency lookup table directly downstream of the RMW cache pipeline.
- Consumes the cache's tbl_wr_* and tbl_rd_* requests.
- Returns read data on tbl_rd_word_* exactly LAT cycles later, echoing the request tag as the completion tag.
- Read data is sampled at request time, so the upstream block sees genuinely stale data for in-flight RMW hazards.

---
 rtl/rmw_long_latency_pkg.sv | 16 +
 rtl/rmw_long_latency_tbl_if.sv | 28 ++
 rtl/rmw_long_latency_tbl_dly.sv | 43 ++++
 rtl/rmw_long_latency_tbl.sv | 71 +++++++
 tb/tb_rmw_long_latency_tbl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rmw_long_latency_pkg.sv
// Shared types and sizing for the long-latency lookup table that sits
// downstream of the RMW cache pipeline.
package rmw_long_latency_pkg;

   localparam int ID_N   = 16;
   localparam int WORD_W = 32;
   localparam int TAG_W  = 4;
   localparam int LAT    = 8;
   localparam int ID_W   = $clog2(ID_N);
   localparam int INFL_W = 6;

   typedef logic [ID_W-1:0]   id_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [TAG_W-1:0]  tag_t;

endpackage

// File: rtl/rmw_long_latency_tbl_if.sv
// Request/response bundle between the RMW cache (master) and the table (slave).
interface rmw_long_latency_tbl_if;
   import rmw_long_latency_pkg::*;

   logic              tbl_wr_r;
   id_t               tbl_wr_id_r;
   word_t             tbl_wr_word_r;
   logic              tbl_rd_r;
   id_t               tbl_rd_id_r;
   tag_t              tbl_rd_itag_r;
   logic              tbl_rd_word_vld_r;
   word_t             tbl_rd_word_r;
   tag_t              tbl_rd_ctag_r;
   logic [INFL_W-1:0] tbl_rd_inflight_r;

   modport master (
      output tbl_wr_r, tbl_wr_id_r, tbl_wr_word_r,
      output tbl_rd_r, tbl_rd_id_r, tbl_rd_itag_r,
      input  tbl_rd_word_vld_r, tbl_rd_word_r, tbl_rd_ctag_r, tbl_rd_inflight_r
   );

   modport slave (
      input  tbl_wr_r, tbl_wr_id_r, tbl_wr_word_r,
      input  tbl_rd_r, tbl_rd_id_r, tbl_rd_itag_r,
      output tbl_rd_word_vld_r, tbl_rd_word_r, tbl_rd_ctag_r, tbl_rd_inflight_r
   );

endinterface

// File: rtl/rmw_long_latency_tbl_dly.sv
// Fixed-depth valid/payload delay line; each stage only takes a new payload
// when the valid arriving with it is set, so the last stage holds old data.
module rmw_long_latency_tbl_dly #(
   parameter int STAGES = 8,
   parameter int DATA_W = 36
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_data
);

   logic [STAGES-1:0] vld_q, vld_d;
   logic [DATA_W-1:0] data_q [STAGES];
   logic [DATA_W-1:0] data_d [STAGES];

   always_comb begin
      vld_d    = '0;
      data_d   = data_q;
      vld_d[0] = in_vld;
      if (in_vld) data_d[0] = in_data;
      for (int i = 1; i < STAGES; i++) begin
         vld_d[i] = vld_q[i-1];
         if (vld_q[i-1]) data_d[i] = data_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign out_vld  = vld_q[STAGES-1];
   assign out_data = data_q[STAGES-1];

endmodule

// File: rtl/rmw_long_latency_tbl.sv
// Long-latency lookup table: reads sample storage at request time and return
// exactly LAT cycles later with the issue tag echoed as the completion tag.
module rmw_long_latency_tbl #(
   parameter int LAT = rmw_long_latency_pkg::LAT
) (
   input  logic                   clk,
   input  logic                   rst,
   rmw_long_latency_tbl_if.slave  tbl
);
   import rmw_long_latency_pkg::*;

   localparam int PAY_W = WORD_W + TAG_W;

   word_t             mem_q [ID_N];
   word_t             mem_d [ID_N];
   logic [INFL_W-1:0] inflight_q, inflight_d;
   logic [PAY_W-1:0]  rd_pay;
   logic [PAY_W-1:0]  resp_pay;
   logic              resp_vld;

   // Read data comes from the pre-write array, so a same-edge write is not seen.
   assign rd_pay = {mem_q[tbl.tbl_rd_id_r], tbl.tbl_rd_itag_r};

   always_comb begin
      mem_d = mem_q;
      if (tbl.tbl_wr_r) mem_d[tbl.tbl_wr_id_r] = tbl.tbl_wr_word_r;
   end

   always_comb begin
      inflight_d = inflight_q + INFL_W'(tbl.tbl_rd_r) - INFL_W'(resp_vld);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < ID_N; i++) mem_q[i] <= '0;
         inflight_q <= '0;
      end else begin
         mem_q      <= mem_d;
         inflight_q <= inflight_d;
      end
   end

   rmw_long_latency_tbl_dly #(
      .STAGES (LAT),
      .DATA_W (PAY_W)
   ) u_dly (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (tbl.tbl_rd_r),
      .in_data  (rd_pay),
      .out_vld  (resp_vld),
      .out_data (resp_pay)
   );

   assign tbl.tbl_rd_word_vld_r = resp_vld;
   assign tbl.tbl_rd_word_r     = resp_pay[PAY_W-1:TAG_W];
   assign tbl.tbl_rd_ctag_r     = resp_pay[TAG_W-1:0];
   assign tbl.tbl_rd_inflight_r = inflight_q;

`ifndef SYNTHESIS
   a_wr_id_range: assert property (@(posedge clk) disable iff (!rst)
      tbl.tbl_wr_r |-> (32'(tbl.tbl_wr_id_r) < ID_N));
   a_rd_id_range: assert property (@(posedge clk) disable iff (!rst)
      tbl.tbl_rd_r |-> (32'(tbl.tbl_rd_id_r) < ID_N));
   a_inflight_max: assert property (@(posedge clk) disable iff (!rst)
      32'(inflight_q) <= LAT);
   a_strobe_known: assert property (@(posedge clk) disable iff (!rst)
      !$isunknown({tbl.tbl_wr_r, tbl.tbl_rd_r}));
`endif

endmodule

// File: tb/tb_rmw_long_latency_tbl.sv
// Bench for rmw_long_latency_tbl: two instances (LAT=8 and LAT=1) share one
// stimulus stream and are compared every cycle against a request-queue model.
module tb_rmw_long_latency_tbl;
   import rmw_long_latency_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   rmw_long_latency_tbl_if if8 ();
   rmw_long_latency_tbl_if if1 ();

   rmw_long_latency_tbl #(.LAT(8)) u_dut8 (.clk(clk), .rst(rst), .tbl(if8));
   rmw_long_latency_tbl #(.LAT(1)) u_dut1 (.clk(clk), .rst(rst), .tbl(if1));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic wr, input int wid, input logic [31:0] wd,
                        input logic rd, input int rid, input int tg);
      if8.tbl_wr_r = wr;  if8.tbl_wr_id_r = id_t'(wid);  if8.tbl_wr_word_r = word_t'(wd);
      if8.tbl_rd_r = rd;  if8.tbl_rd_id_r = id_t'(rid);  if8.tbl_rd_itag_r = tag_t'(tg);
      if1.tbl_wr_r = wr;  if1.tbl_wr_id_r = id_t'(wid);  if1.tbl_wr_word_r = word_t'(wd);
      if1.tbl_rd_r = rd;  if1.tbl_rd_id_r = id_t'(rid);  if1.tbl_rd_itag_r = tag_t'(tg);
   endtask

   task automatic idle();
      drive(1'b0, 0, 32'h0, 1'b0, 0, 0);
   endtask

   // Model: a table plus, per instance, a FIFO of pending responses stamped
   // with the edge after which each must become visible.
   word_t mem_m [ID_N];
   int    due_m [2][64];
   word_t wq_m  [2][64];
   tag_t  tq_m  [2][64];
   int    head_m [2];
   int    tail_m [2];
   logic  m_vld  [2];
   word_t m_word [2];
   tag_t  m_tag  [2];
   int    cyc = 0;
   bit    model_on = 1'b0;

   always @(posedge clk) begin : model
      int idx;
      int lat;
      if (!rst) begin
         for (int i = 0; i < ID_N; i++) mem_m[i] = '0;
         for (int k = 0; k < 2; k++) begin
            head_m[k] = 0; tail_m[k] = 0;
            m_vld[k] = 1'b0; m_word[k] = '0; m_tag[k] = '0;
         end
         model_on = 1'b1;
      end else begin
         for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 8 : 1;
            if (if8.tbl_rd_r) begin
               idx = tail_m[k] % 64;
               due_m[k][idx] = cyc + lat - 1;
               wq_m[k][idx]  = mem_m[if8.tbl_rd_id_r];
               tq_m[k][idx]  = if8.tbl_rd_itag_r;
               tail_m[k]++;
            end
         end
         if (if8.tbl_wr_r) mem_m[if8.tbl_wr_id_r] = if8.tbl_wr_word_r;
         for (int k = 0; k < 2; k++) begin
            m_vld[k] = 1'b0;
            idx = head_m[k] % 64;
            if (head_m[k] != tail_m[k] && due_m[k][idx] == cyc) begin
               m_vld[k]  = 1'b1;
               m_word[k] = wq_m[k][idx];
               m_tag[k]  = tq_m[k][idx];
               head_m[k]++;
            end
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("m8_vld",  if8.tbl_rd_word_vld_r, m_vld[0]);
         chk("m8_word", if8.tbl_rd_word_r,     m_word[0]);
         chk("m8_ctag", if8.tbl_rd_ctag_r,     m_tag[0]);
         chk("m8_infl", if8.tbl_rd_inflight_r, tail_m[0] - head_m[0] + int'(m_vld[0]));
         chk("m1_vld",  if1.tbl_rd_word_vld_r, m_vld[1]);
         chk("m1_word", if1.tbl_rd_word_r,     m_word[1]);
         chk("m1_ctag", if1.tbl_rd_ctag_r,     m_tag[1]);
         chk("m1_infl", if1.tbl_rd_inflight_r, tail_m[1] - head_m[1] + int'(m_vld[1]));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pk;
      int nresp;
      rst = 1'b0;
      idle();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      chk("rst_vld",  if8.tbl_rd_word_vld_r, 0);
      chk("rst_word", if8.tbl_rd_word_r,     0);
      chk("rst_ctag", if8.tbl_rd_ctag_r,     0);
      chk("rst_infl", if8.tbl_rd_inflight_r, 0);

      // 1: read id 3 tag 5 out of reset
      drive(1'b0, 0, 32'h0, 1'b1, 3, 5);
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (j == 1) idle();
         chk("t1_vld",  if8.tbl_rd_word_vld_r, (j == 8) ? 1 : 0);
         chk("t1_infl", if8.tbl_rd_inflight_r, (j <= 8) ? 1 : 0);
         if (j == 8) begin
            chk("t1_word", if8.tbl_rd_word_r, 0);
            chk("t1_ctag", if8.tbl_rd_ctag_r, 5);
         end
      end

      // 2: write id 7 then read it next cycle
      drive(1'b1, 7, 32'hAA, 1'b0, 0, 0);
      @(negedge clk);
      drive(1'b0, 0, 32'h0, 1'b1, 7, 1);
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         if (j == 1) idle();
         if (j == 8) begin
            chk("t2_vld",  if8.tbl_rd_word_vld_r, 1);
            chk("t2_word", if8.tbl_rd_word_r, 32'hAA);
            chk("t2_ctag", if8.tbl_rd_ctag_r, 1);
         end
         if (j == 9) begin
            chk("t2_hold_vld",  if8.tbl_rd_word_vld_r, 0);
            chk("t2_hold_word", if8.tbl_rd_word_r, 32'hAA);
         end
      end

      // 3: same-edge write/read of id 2 returns the old value
      drive(1'b1, 2, 32'h11, 1'b0, 0, 0);
      @(negedge clk);
      drive(1'b1, 2, 32'h55, 1'b1, 2, 9);
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (j == 1) drive(1'b0, 0, 32'h0, 1'b1, 2, 10);
         else if (j == 2) idle();
         if (j == 8) begin
            chk("t3_old_vld",  if8.tbl_rd_word_vld_r, 1);
            chk("t3_old_word", if8.tbl_rd_word_r, 32'h11);
            chk("t3_old_ctag", if8.tbl_rd_ctag_r, 9);
         end
         if (j == 9) begin
            chk("t3_new_word", if8.tbl_rd_word_r, 32'h55);
            chk("t3_new_ctag", if8.tbl_rd_ctag_r, 10);
         end
      end

      // 4: eight back-to-back reads
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, i, 32'h100 + i, 1'b0, 0, 0);
         @(negedge clk);
      end
      drive(1'b0, 0, 32'h0, 1'b1, 0, 0);
      pk = 0;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         if (j < 8) drive(1'b0, 0, 32'h0, 1'b1, j, j);
         else idle();
         if (int'(if8.tbl_rd_inflight_r) > pk) pk = int'(if8.tbl_rd_inflight_r);
         chk("t4_vld", if8.tbl_rd_word_vld_r, (j >= 8 && j <= 15) ? 1 : 0);
         if (j >= 8 && j <= 15) begin
            chk("t4_word", if8.tbl_rd_word_r, 32'h100 + j - 8);
            chk("t4_ctag", if8.tbl_rd_ctag_r, j - 8);
         end
      end
      chk("t4_peak", pk, 8);

      // 5: reset drops in-flight reads and clears storage
      drive(1'b0, 0, 32'h0, 1'b1, 0, 1);
      @(negedge clk);
      drive(1'b0, 0, 32'h0, 1'b1, 1, 2);
      @(negedge clk);
      drive(1'b0, 0, 32'h0, 1'b1, 2, 3);
      @(negedge clk);
      idle();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("t5_infl", if8.tbl_rd_inflight_r, 0);
      for (int j = 0; j < 12; j++) begin
         chk("t5_novld", if8.tbl_rd_word_vld_r, 0);
         @(negedge clk);
      end
      nresp = 0;
      for (int j = 0; j < 26; j++) begin
         if (j < 16) drive(1'b0, 0, 32'h0, 1'b1, j, j);
         else idle();
         if (if8.tbl_rd_word_vld_r === 1'b1) begin
            nresp++;
            chk("t5_zero", if8.tbl_rd_word_r, 0);
         end
         @(negedge clk);
      end
      chk("t5_nresp", nresp, 16);

      // 6: LAT=1 instance answers the very next cycle
      drive(1'b1, 15, 32'hFFFF_FFFF, 1'b0, 0, 0);
      @(negedge clk);
      drive(1'b0, 0, 32'h0, 1'b1, 15, 3);
      @(negedge clk);
      idle();
      chk("t6_vld",  if1.tbl_rd_word_vld_r, 1);
      chk("t6_word", if1.tbl_rd_word_r, 32'hFFFF_FFFF);
      chk("t6_ctag", if1.tbl_rd_ctag_r, 3);
      @(negedge clk);
      chk("t6_vld_off", if1.tbl_rd_word_vld_r, 0);
      chk("t6_hold",    if1.tbl_rd_word_r, 32'hFFFF_FFFF);
      repeat (6) @(negedge clk);
      chk("t6_l8_vld",  if8.tbl_rd_word_vld_r, 1);
      chk("t6_l8_word", if8.tbl_rd_word_r, 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
